// File: rtl/uart_byte_receiver_pkg.sv
// Shared types and defaults for the UART byte receiver.
// Pulled in by the receiver top and its testbench.
package uart_byte_receiver_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } UartRxState_t;

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Bundles the RX line and the byte strobe bus feeding the escape-sequence parser.
// The slave modport is the receiver side; the master modport is the line driver / consumer side.
interface uart_byte_receiver_if;

  logic       rxd;
  logic [7:0] data;
  logic       dataReady;
  logic       frameError;
  logic       busy;

  modport slave  (input rxd, output data, output dataReady, output frameError, output busy);
  modport master (output rxd, input data, input dataReady, input frameError, input busy);

endinterface

// File: rtl/uart_byte_receiver_sample_tick.sv
// Oversample prescaler: counts 0..DIV-1 while enabled and pulses o_tick on the last count.
// Dropping i_en clears the count, so every frame starts from a known phase.
module uart_sample_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: synchronizes rxd, majority-votes each bit at mid-period and
// emits one-cycle dataReady / frameError strobes toward the escape-sequence parser.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | qualifying the start bit (glitch rejection)
//   DATA  | shifting in 8 data bits, LSB first
//   STOP  | checking the stop bit
//   BREAK | stop bit was low; waiting for the line to return high
module uart_byte_receiver
  import uart_byte_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_byte_receiver_if.slave  bus
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;

  localparam logic [SW-1:0] SI_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SI_VA   = SW'(M - 1);
  localparam logic [SW-1:0] SI_VB   = SW'(M);
  localparam logic [SW-1:0] SI_DEC  = SW'(M + 1);

  UartRxState_t r_state, w_state_next;

  logic          r_sync1, r_sync2;
  logic [1:0]    r_fill;
  logic          r_rxs_prev;
  logic [SW-1:0] r_si;
  logic [2:0]    r_bitcnt;
  logic [1:0]    r_votes;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_ready;
  logic          r_ferr;

  logic w_rxs, w_fall, w_busy, w_tick, w_dec, w_bit_end, w_vote;
  logic w_load, w_ferr_set, w_shift_en;

  assign w_rxs     = r_sync2;
  assign w_busy    = (r_state != IDLE);
  assign w_fall    = !w_rxs && r_rxs_prev;
  assign w_dec     = w_tick && (r_si == SI_DEC);
  assign w_bit_end = w_tick && (r_si == SI_LAST);
  assign w_vote    = (r_votes[0] & r_votes[1]) | (r_votes[0] & w_rxs) | (r_votes[1] & w_rxs);

  uart_sample_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_busy),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_next = START;
      START:   if (w_dec && w_vote) w_state_next = IDLE;
               else if (w_bit_end) w_state_next = DATA;
      DATA:    if (w_bit_end && (r_bitcnt == 3'd7)) w_state_next = STOP;
      STOP:    if (w_dec) w_state_next = w_vote ? IDLE : BREAK;
      BREAK:   if (w_rxs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_load     = (r_state == STOP) && w_dec && w_vote;
    w_ferr_set = (r_state == STOP) && w_dec && !w_vote;
    w_shift_en = (r_state == DATA) && w_dec;
  end

  // r_rxs_prev only becomes 1 from a real line sample, so a line held low
  // through reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_fill     <= 2'b00;
      r_rxs_prev <= 1'b0;
    end else begin
      r_sync1    <= bus.rxd;
      r_sync2    <= r_sync1;
      r_fill     <= {r_fill[0], 1'b1};
      r_rxs_prev <= r_fill[1] ? w_rxs : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_si     <= '0;
      r_bitcnt <= 3'd0;
      r_votes  <= 2'b00;
      r_shift  <= 8'h00;
      r_data   <= 8'h00;
      r_ready  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_ready <= w_load;
      r_ferr  <= w_ferr_set;
      if (w_load) r_data <= r_shift;
      if (w_shift_en) r_shift <= {w_vote, r_shift[7:1]};

      if (r_state == IDLE)  r_si <= '0;
      else if (w_tick)      r_si <= (r_si == SI_LAST) ? '0 : r_si + 1'b1;

      if (w_tick && (r_si == SI_VA)) r_votes[0] <= w_rxs;
      if (w_tick && (r_si == SI_VB)) r_votes[1] <= w_rxs;

      if (r_state != DATA) r_bitcnt <= 3'd0;
      else if (w_bit_end)  r_bitcnt <= r_bitcnt + 3'd1;
    end
  end

  assign bus.data       = r_data;
  assign bus.dataReady  = r_ready;
  assign bus.frameError = r_ferr;
  assign bus.busy       = w_busy;

endmodule
